// File: rtl/string_stream_writer_pkg.sv
// Shared types and character constants for the string stream writer.
package string_stream_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      GAP,
      CR,
      LF,
      FINISH
   } state_t;

   localparam logic [7:0] CHAR_NUL = 8'h00;
   localparam logic [7:0] CHAR_CR  = 8'h0D;
   localparam logic [7:0] CHAR_LF  = 8'h0A;

endpackage

// File: rtl/string_stream_writer_if.sv
// Byte stream valid/ready link between the string writer and the UART transmitter.
interface string_stream_writer_if;
   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic       tx_data_ready;

   modport master (output tx_data, output tx_data_valid, input tx_data_ready);
   modport slave  (input tx_data, input tx_data_valid, output tx_data_ready);
endinterface

// File: rtl/string_stream_writer_gap_timer.sv
// Inter-character gap timer: load on entry to the gap, count down, flag the last gap cycle.
module gap_timer #(
   parameter int LOAD_VAL = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   output logic expired_o
);
   localparam int W = (LOAD_VAL > 0) ? $clog2(LOAD_VAL + 1) : 1;

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= W'(LOAD_VAL);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   // loaded value is seen in the first gap cycle, so terminal count is 1
   assign expired_o = (cnt_q == W'(1));
endmodule

// File: rtl/string_stream_writer.sv
// Emits a latched packed string byte by byte on a valid/ready stream, stopping at the first NUL.
// Optional CR/LF terminator enabled by defining STRING_STREAM_CRLF_EN.
//
// state  | meaning
// IDLE   | waiting for send; chars_sent holds last count
// LOAD   | string latched, head byte inspected
// SEND   | head byte offered, waiting for handshake
// GAP    | idle clocks between accepted bytes
// CR     | offering 8'h0D (CRLF builds only)
// LF     | offering 8'h0A (CRLF builds only)
// FINISH | one-cycle done pulse
module string_stream_writer
   import string_stream_pkg::*;
#(
   parameter int MAX_CHARS       = 82,
   parameter int CHAR_GAP_CYCLES = 0,
   parameter int CNT_W           = $clog2(MAX_CHARS + 3)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [MAX_CHARS*8-1:0] line_i,
   input  logic                   send,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_W-1:0]       chars_sent,
   string_stream_writer_if.master tx
);
   localparam int LW = MAX_CHARS * 8;
   localparam int RW = $clog2(MAX_CHARS + 1);
`ifdef STRING_STREAM_CRLF_EN
   localparam state_t TERM_FIRST = CR;
`else
   localparam state_t TERM_FIRST = FINISH;
`endif

   state_t           state_q, state_d, gap_ret_q, gap_ret_d, dst;
   logic [LW-1:0]    shift_q, shift_d, shift_nx;
   logic [RW-1:0]    rem_q, rem_d;
   logic [CNT_W-1:0] chars_q, chars_d;
   logic [7:0]       head, next_head;
   logic             hs, take, gap_expired;

   assign shift_nx  = shift_q << 8;
   assign head      = shift_q[LW-1 -: 8];
   assign next_head = shift_nx[LW-1 -: 8];

   always_comb begin
      tx.tx_data       = CHAR_NUL;
      tx.tx_data_valid = 1'b0;
      case (state_q)
         SEND: begin
            tx.tx_data       = head;
            tx.tx_data_valid = 1'b1;
         end
`ifdef STRING_STREAM_CRLF_EN
         CR: begin
            tx.tx_data       = CHAR_CR;
            tx.tx_data_valid = 1'b1;
         end
         LF: begin
            tx.tx_data       = CHAR_LF;
            tx.tx_data_valid = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign hs = tx.tx_data_valid && tx.tx_data_ready;

   always_comb begin
      state_d   = state_q;
      gap_ret_d = gap_ret_q;
      shift_d   = shift_q;
      rem_d     = rem_q;
      chars_d   = chars_q;
      dst       = FINISH;
      take      = 1'b0;
      case (state_q)
         IDLE: begin
            if (send) begin
               shift_d = line_i;
               rem_d   = RW'(MAX_CHARS);
               chars_d = '0;
               state_d = LOAD;
            end
         end
         LOAD: state_d = (head == CHAR_NUL) ? TERM_FIRST : SEND;
         SEND: begin
            if (hs) begin
               take    = 1'b1;
               chars_d = chars_q + CNT_W'(1);
               shift_d = shift_nx;
               rem_d   = rem_q - RW'(1);
               dst     = (rem_q == RW'(1) || next_head == CHAR_NUL) ? TERM_FIRST : SEND;
            end
         end
         GAP: begin
            if (gap_expired) state_d = gap_ret_q;
         end
`ifdef STRING_STREAM_CRLF_EN
         CR: begin
            if (hs) begin
               take    = 1'b1;
               chars_d = chars_q + CNT_W'(1);
               dst     = LF;
            end
         end
         LF: begin
            if (hs) begin
               take    = 1'b1;
               chars_d = chars_q + CNT_W'(1);
               dst     = FINISH;
            end
         end
`endif
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // the gap follows every accepted byte except the one that ends the transfer
      if (take) begin
         if (dst == FINISH) begin
            state_d = FINISH;
         end else if (CHAR_GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_ret_d = dst;
         end else begin
            state_d = dst;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         gap_ret_q <= SEND;
         shift_q   <= '0;
         rem_q     <= '0;
         chars_q   <= '0;
      end else begin
         state_q   <= state_d;
         gap_ret_q <= gap_ret_d;
         shift_q   <= shift_d;
         rem_q     <= rem_d;
         chars_q   <= chars_d;
      end
   end

   generate
      if (CHAR_GAP_CYCLES > 0) begin : g_gap
         logic gap_load;
         assign gap_load = take && (state_d == GAP);
         gap_timer #(.LOAD_VAL(CHAR_GAP_CYCLES)) u_gap_timer (
            .clk       (clk),
            .rst       (rst),
            .load_i    (gap_load),
            .expired_o (gap_expired)
         );
      end else begin : g_no_gap
         assign gap_expired = 1'b1;
      end
   endgenerate

   assign busy       = (state_q != IDLE);
   assign done       = (state_q == FINISH);
   assign chars_sent = chars_q;
endmodule

// File: tb/tb_string_stream_writer.sv
// Directed bench: two 4-char writers, one without gap and one with a 3-cycle gap.
module tb_string_stream_writer;
`ifdef STRING_STREAM_CRLF_EN
   localparam int CRLF = 1;
`else
   localparam int CRLF = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] line0, line1;
   logic        send0, send1, rdy0, rdy1;
   logic        busy0, busy1, done0, done1;
   logic [2:0]  chars0, chars1;

   string_stream_writer_if if0 ();
   string_stream_writer_if if1 ();
   assign if0.tx_data_ready = rdy0;
   assign if1.tx_data_ready = rdy1;

   string_stream_writer #(.MAX_CHARS(4), .CHAR_GAP_CYCLES(0)) u0 (
      .clk(clk), .rst(rst), .line_i(line0), .send(send0), .busy(busy0),
      .done(done0), .chars_sent(chars0), .tx(if0));
   string_stream_writer #(.MAX_CHARS(4), .CHAR_GAP_CYCLES(3)) u1 (
      .clk(clk), .rst(rst), .line_i(line1), .send(send1), .busy(busy1),
      .done(done1), .chars_sent(chars1), .tx(if1));

   int tests = 0;
   int fails = 0;

   logic [7:0] cap_byte [16];
   int         cap_cyc  [16];
   int         n_bytes, n_valid, done_cyc, n_done, unstable;
   logic       busy_first;

   // records the stream for cycles 1..budget after a send issued at cycle 0
   task automatic capture(input int dut, input int budget, input bit tog);
      logic v, r, dn, pv, pr;
      logic [7:0] d, pd;
      n_bytes = 0; n_valid = 0; done_cyc = -1; n_done = 0; unstable = 0;
      busy_first = 1'b0; pv = 1'b0; pr = 1'b0; pd = 8'h00;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (dut == 0) begin
            send0 = 1'b0;
            rdy0  = tog ? ((c % 2) == 1) : 1'b1;
            v = if0.tx_data_valid; d = if0.tx_data; r = rdy0; dn = done0;
            if (c == 1) busy_first = busy0;
         end else begin
            send1 = 1'b0;
            rdy1  = tog ? ((c % 2) == 1) : 1'b1;
            v = if1.tx_data_valid; d = if1.tx_data; r = rdy1; dn = done1;
            if (c == 1) busy_first = busy1;
         end
         if (pv && !pr && (!v || d !== pd)) unstable++;
         if (v) n_valid++;
         if (v && r && n_bytes < 16) begin
            cap_byte[n_bytes] = d;
            cap_cyc[n_bytes]  = c;
            n_bytes++;
         end
         if (dn) begin
            n_done++;
            if (done_cyc < 0) done_cyc = c;
         end
         pv = v; pr = r; pd = d;
         if (done_cyc >= 0 && c >= done_cyc + 2) break;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy0); end
      tests++; if (done0 !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done0); end
      tests++; if (chars0 !== 3'd0) begin fails++; $display("FAIL reset_chars: got %0d expected 0", chars0); end
      tests++; if (if0.tx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", if0.tx_data); end
      tests++; if (if0.tx_data_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", if0.tx_data_valid); end
      tests++; if (if1.tx_data_valid !== 1'b0 || busy1 !== 1'b0) begin
         fails++; $display("FAIL reset_gap_dut: got valid=%b busy=%b expected 0 0", if1.tx_data_valid, busy1); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [7:0] eb [4] = '{8'h48, 8'h49, 8'h0D, 8'h0A};
      int         ec [4] = '{2, 3, 4, 5};
      int         en = 2 + 2 * CRLF;
      @(negedge clk);
      line0 = {8'h48, 8'h49, 8'h00, 8'h00};
      send0 = 1'b1;
      capture(0, 40, 1'b0);
      tests++; if (busy_first !== 1'b1) begin fails++; $display("FAIL hi_busy_after_send: got %b expected 1", busy_first); end
      tests++; if (n_bytes != en) begin fails++; $display("FAIL hi_byte_count: got %0d expected %0d", n_bytes, en); end
      for (int i = 0; i < en; i++) begin
         tests++;
         if (cap_byte[i] !== eb[i] || cap_cyc[i] != ec[i]) begin
            fails++; $display("FAIL hi_byte%0d: got %h@%0d expected %h@%0d", i, cap_byte[i], cap_cyc[i], eb[i], ec[i]);
         end
      end
      tests++; if (done_cyc != 4 + 2 * CRLF || n_done != 1) begin
         fails++; $display("FAIL hi_done: got cycle %0d pulses %0d expected cycle %0d pulses 1", done_cyc, n_done, 4 + 2 * CRLF); end
      tests++; if (chars0 !== 3'(en)) begin fails++; $display("FAIL hi_chars: got %0d expected %0d", chars0, en); end
   endtask

   task automatic test_full_toggle();
      logic [7:0] eb [6] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
      int         ec [6] = '{3, 5, 7, 9, 11, 13};
      int         en = 4 + 2 * CRLF;
      @(negedge clk);
      line0 = {8'h41, 8'h42, 8'h43, 8'h44};
      send0 = 1'b1;
      @(posedge clk);
      #1 line0 = {8'h5A, 8'h5A, 8'h5A, 8'h5A};
      capture(0, 40, 1'b1);
      tests++; if (n_bytes != en) begin fails++; $display("FAIL full_byte_count: got %0d expected %0d", n_bytes, en); end
      for (int i = 0; i < en; i++) begin
         tests++;
         if (cap_byte[i] !== eb[i] || cap_cyc[i] != ec[i]) begin
            fails++; $display("FAIL full_byte%0d: got %h@%0d expected %h@%0d", i, cap_byte[i], cap_cyc[i], eb[i], ec[i]);
         end
      end
      tests++; if (unstable != 0) begin fails++; $display("FAIL full_hold_stable: got %0d changes expected 0", unstable); end
      tests++; if (done_cyc != 10 + 4 * CRLF) begin fails++; $display("FAIL full_done: got %0d expected %0d", done_cyc, 10 + 4 * CRLF); end
      tests++; if (chars0 !== 3'(en)) begin fails++; $display("FAIL full_chars: got %0d expected %0d", chars0, en); end
   endtask

   task automatic test_gap();
      logic [7:0] eb [4] = '{8'h58, 8'h59, 8'h0D, 8'h0A};
      int         ec [4] = '{2, 6, 10, 14};
      int         en = 2 + 2 * CRLF;
      @(negedge clk);
      line1 = {8'h58, 8'h59, 8'h00, 8'h00};
      send1 = 1'b1;
      capture(1, 60, 1'b0);
      tests++; if (n_bytes != en) begin fails++; $display("FAIL gap_byte_count: got %0d expected %0d", n_bytes, en); end
      for (int i = 0; i < en; i++) begin
         tests++;
         if (cap_byte[i] !== eb[i] || cap_cyc[i] != ec[i]) begin
            fails++; $display("FAIL gap_byte%0d: got %h@%0d expected %h@%0d", i, cap_byte[i], cap_cyc[i], eb[i], ec[i]);
         end
      end
      tests++; if (n_valid != en) begin fails++; $display("FAIL gap_valid_cycles: got %0d expected %0d", n_valid, en); end
      tests++; if (done_cyc != 7 + 8 * CRLF) begin fails++; $display("FAIL gap_done: got %0d expected %0d", done_cyc, 7 + 8 * CRLF); end
      tests++; if (chars1 !== 3'(en)) begin fails++; $display("FAIL gap_chars: got %0d expected %0d", chars1, en); end
   endtask

   task automatic test_empty();
      int en = 2 * CRLF;
      @(negedge clk);
      line0 = 32'h0;
      send0 = 1'b1;
      capture(0, 40, 1'b0);
      tests++; if (n_valid != en) begin fails++; $display("FAIL empty_valid_cycles: got %0d expected %0d", n_valid, en); end
      tests++; if (done_cyc != 2 + 2 * CRLF) begin fails++; $display("FAIL empty_done: got %0d expected %0d", done_cyc, 2 + 2 * CRLF); end
      tests++; if (chars0 !== 3'(en)) begin fails++; $display("FAIL empty_chars: got %0d expected %0d", chars0, en); end
      if (CRLF == 1) begin
         tests++;
         if (cap_byte[0] !== 8'h0D || cap_byte[1] !== 8'h0A) begin
            fails++; $display("FAIL empty_crlf: got %h %h expected 0d 0a", cap_byte[0], cap_byte[1]);
         end
      end
   endtask

   task automatic test_send_at_done();
      bit found = 1'b0;
      @(negedge clk);
      line0 = {8'h48, 8'h49, 8'h00, 8'h00};
      send0 = 1'b1; rdy0 = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         send0 = 1'b0;
         if (done0) begin
            line0 = {8'h51, 8'h00, 8'h00, 8'h00};
            send0 = 1'b1;
            found = 1'b1;
            break;
         end
      end
      tests++; if (!found) begin fails++; $display("FAIL sad_timeout: got no done expected done"); end
      @(negedge clk);
      send0 = 1'b0;
      tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL sad_busy1: got %b expected 0", busy0); end
      @(negedge clk);
      tests++; if (busy0 !== 1'b0 || if0.tx_data_valid !== 1'b0) begin
         fails++; $display("FAIL sad_busy2: got busy=%b valid=%b expected 0 0", busy0, if0.tx_data_valid); end
   endtask

   task automatic test_abort();
      int bad = 0;
      @(negedge clk);
      line0 = {8'h41, 8'h42, 8'h00, 8'h00};
      send0 = 1'b1; rdy0 = 1'b1;
      @(negedge clk);
      send0 = 1'b0;
      @(negedge clk);
      tests++; if (if0.tx_data_valid !== 1'b1 || if0.tx_data !== 8'h41) begin
         fails++; $display("FAIL abort_first: got valid=%b data=%h expected 1 41", if0.tx_data_valid, if0.tx_data); end
      send0 = 1'b1;
      @(negedge clk);
      send0 = 1'b0; rdy0 = 1'b0;
      tests++; if (if0.tx_data_valid !== 1'b1 || if0.tx_data !== 8'h42 || chars0 !== 3'd1) begin
         fails++; $display("FAIL abort_second: got valid=%b data=%h chars=%0d expected 1 42 1", if0.tx_data_valid, if0.tx_data, chars0); end
      @(negedge clk);
      tests++; if (if0.tx_data !== 8'h42) begin fails++; $display("FAIL abort_hold: got %h expected 42", if0.tx_data); end
      rst = 1'b1;
      @(negedge clk);
      tests++; if (if0.tx_data_valid !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
         fails++; $display("FAIL abort_reset: got valid=%b busy=%b done=%b expected 0 0 0", if0.tx_data_valid, busy0, done0); end
      rst = 1'b0; rdy0 = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done0 || if0.tx_data_valid || busy0) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL abort_quiet: got %0d active cycles expected 0", bad); end
   endtask

   initial begin
      rst = 1'b1; send0 = 1'b0; send1 = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
      line0 = 32'h0; line1 = 32'h0;
      test_reset();
      test_back_to_back();
      test_full_toggle();
      test_gap();
      test_empty();
      test_send_at_done();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/string_stream_writer.md
Name: string_stream_writer

Overview:
- Parametrised successor of the single-character UART string sender.
- On a `send` strobe, latches a fixed-width packed string of up to MAX_CHARS bytes and emits it byte by byte on a valid/ready byte stream. Emission is first character first and stops at the first NUL.
- Supports a programmable inter-character gap and reports `busy`, `done` and a sent-byte count.
- Sits between line-producing logic (e.g. the SD-card file reader) and the existing uart_tx instance, which the parent wires to tx_data/tx_data_valid/tx_data_ready.

Parameters:
- MAX_CHARS, 82: capacity of line_i in bytes; must be >= 1.
- CHAR_GAP_CYCLES, 0: idle clocks inserted after each accepted byte before the next is offered.
- CNT_W, $clog2(MAX_CHARS+3): width of chars_sent; the +2 covers CR/LF.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- line_i  in  MAX_CHARS*8  packed string; first char is bits [MAX_CHARS*8-1 -: 8].
- send  in  1  start request; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted send until done.
- done  out  1  one-cycle pulse when the transfer completes.
- chars_sent  out  CNT_W  bytes accepted by the sink in the current/last transfer.
- tx_data  out  8  byte offered.
- tx_data_valid  out  1  tx_data valid.
- tx_data_ready  in  1  sink accepts when valid&&ready.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- Reset values: busy=0, done=0, chars_sent=0, tx_data=8'h00, tx_data_valid=0; FSM enters IDLE.
- Reset mid-transfer aborts immediately: valid drops the next edge, no done pulse, shift register contents are don't-care.
- States:
  - IDLE: on send=1, latch line_i into the shift register, clear chars_sent, go to LOAD.
  - LOAD: if the head byte is 8'h00, go to FINISH (empty string). Otherwise drive tx_data=head, set valid=1, go to SEND.
  - SEND: hold valid and tx_data stable until valid&&ready. On handshake:
    - chars_sent++ and shift left 8 bits, filling with 8'h00.
    - Decrement the remaining counter, initialised to MAX_CHARS.
    - If remaining reaches 0 or the new head is 00: go to FINISH (valid=0).
    - Else if CHAR_GAP_CYCLES>0: valid=0 and go to GAP.
    - Else (gap=0): present the new head with valid held high the next cycle (back-to-back).
  - GAP: count CHAR_GAP_CYCLES cycles with valid=0, then present the head, valid=1, go to SEND.
  - FINISH: done=1 for this cycle, busy=0 next, go to IDLE.
- Latency:
  - send in cycle N gives busy=1 and LOAD in N+1, and first valid in N+2.
  - An empty string gives done in N+2.
  - done asserts the cycle after the last handshake.
- send while busy is ignored; no queueing.
- send coincident with done: ignored, because the FSM is not yet in IDLE.
- Stable input: line_i may change after the latching cycle without effect.
- A full buffer with no NUL sends exactly MAX_CHARS bytes.
- chars_sent saturates only by construction (max MAX_CHARS+2); it holds its value in IDLE.
- tx_data_ready ignored while valid=0.

Optional Feature:
- Macro STRING_STREAM_CRLF_EN.
- When defined: after the last string byte, and before FINISH, send 8'h0D then 8'h0A.
  - Each uses the same handshake and the gap rules.
  - Both count in chars_sent.
  - An empty string still sends CR LF.
- When undefined: no terminator bytes; the FSM has no CR/LF states.

Decomposition:
- Shared package string_stream_pkg:
  - state enum (IDLE, LOAD, SEND, GAP, CR, LF, FINISH);
  - constants CHAR_NUL=8'h00, CHAR_CR=8'h0D, CHAR_LF=8'h0A.
- One natural sub-module: gap_timer, a load/count-down/expired counter of width $clog2(CHAR_GAP_CYCLES+1) (min 1). It is not instantiated when CHAR_GAP_CYCLES=0.

Test Plan:
- MAX_CHARS=4, gap 0, line_i="HI\0\0", ready tied 1, send pulse:
  - tx_data 'H','I' on two consecutive valid cycles;
  - done one cycle after 'I';
  - chars_sent=2.
- MAX_CHARS=4, line_i="ABCD" (no NUL), ready toggling 1/0 each cycle:
  - exactly 4 bytes A,B,C,D;
  - tx_data stable while valid&&!ready;
  - chars_sent=4.
- CHAR_GAP_CYCLES=3, line_i="XY\0\0", ready=1: valid low for exactly 3 cycles between 'X' and 'Y'.
- line_i all zero, send:
  - no valid;
  - done exactly 2 cycles after send;
  - chars_sent=0;
  - with STRING_STREAM_CRLF_EN: bytes 0D,0A then done, chars_sent=2.
- Second send pulse during transfer of "AB", and rst=1 asserted while 'B' is pending with ready=0:
  - the extra send has no effect;
  - after reset: valid=0, busy=0, no done pulse.
